// File: rtl/ascon_seq_pkg.sv
`default_nettype none
// ascon_seq_pkg: shared widths, watchdog limit and sequencer state encoding.
package ascon_seq_pkg;

  localparam int BLK_W       = 64;
  localparam int WORD_W      = 32;
  localparam int TIMEOUT_MAX = 255;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    START    = 4'd1,
    WAIT_REQ = 4'd2,
    RD_LO    = 4'd3,
    RD_HI    = 4'd4,
    LOAD     = 4'd5,
    WAIT_CT  = 4'd6,
    WR_LO    = 4'd7,
    WR_HI    = 4'd8,
    WAIT_TAG = 4'd9,
    DONE     = 4'd10,
    ERR      = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ascon_seq_wdog.sv
`default_nettype none
// ascon_seq_wdog: saturating cycle counter for the sequencer's handshake waits.
module ascon_seq_wdog
  import ascon_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear || !active) begin
      cnt <= '0;
    end else if (cnt != 8'(TIMEOUT_MAX)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = active && (cnt == 8'(TIMEOUT_MAX));

endmodule
`default_nettype wire

// File: rtl/ascon_seq.sv
`default_nettype none
// ascon_seq: moves 64-bit blocks between a 32-bit block memory and an ASCON core.
// Optional watchdog on the core handshake waits is enabled by ASCON_SEQ_TIMEOUT_EN.
module ascon_seq
  import ascon_seq_pkg::*;
#(
  parameter int MEM_AW = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              go_i,
  input  logic              abort_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [4:0]        cfg_adblk_i,
  input  logic [4:0]        cfg_dblk_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              core_start_o,
  output logic [1:0]        core_mode_o,
  output logic [4:0]        core_adlen_o,
  output logic [6:0]        core_datalen_o,
  output logic [BLK_W-1:0]  core_blk_o,
  input  logic              core_blk_req_i,
  input  logic [BLK_W-1:0]  core_ct_i,
  input  logic              core_ctv_i,
  input  logic              core_tv_i
);

  localparam int BLK_LIMIT = 2 ** (MEM_AW - 1);

  state_t              state, state_nx;
  logic [5:0]          k, k_inc, total, req_sum, ad6;
  logic                cfg_bad, accept, timeout;
  logic [WORD_W-1:0]   lo_word;
  logic [BLK_W-1:0]    ct_q;
  logic [MEM_AW-1:0]   addr_lo, addr_hi;

  assign req_sum = {1'b0, cfg_adblk_i} + {1'b0, cfg_dblk_i};
  assign cfg_bad = (32'(req_sum) > BLK_LIMIT) || (cfg_dblk_i > 5'd15);
  assign accept  = (state == IDLE) && go_i && !cfg_bad;
  assign ad6     = {1'b0, core_adlen_o};
  assign k_inc   = k + 6'd1;
  assign addr_lo = MEM_AW'({k, 1'b0});
  assign addr_hi = MEM_AW'({k, 1'b1});

`ifdef ASCON_SEQ_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state == WAIT_REQ) || (state == WAIT_CT) || (state == WAIT_TAG);

  ascon_seq_wdog u_wdog (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .active  (in_wait),
    .clear   (state_nx != state),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (go_i) state_nx = cfg_bad ? ERR : START;
      START:    state_nx = (total == 6'd0) ? WAIT_TAG : WAIT_REQ;
      WAIT_REQ: if (core_blk_req_i) state_nx = RD_LO;
      RD_LO:    state_nx = RD_HI;
      RD_HI:    state_nx = LOAD;
      // An AD block needs no ciphertext; with no data blocks the last AD load goes straight to the tag wait.
      LOAD: begin
        if (k < ad6) state_nx = (k_inc == total) ? WAIT_TAG : WAIT_REQ;
        else         state_nx = WAIT_CT;
      end
      WAIT_CT:  if (core_ctv_i) state_nx = WR_LO;
      WR_LO:    state_nx = WR_HI;
      WR_HI:    state_nx = (k_inc < total) ? WAIT_REQ : WAIT_TAG;
      WAIT_TAG: if (core_tv_i) state_nx = DONE;
      DONE:     state_nx = IDLE;
      ERR:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (timeout) state_nx = ERR;
    if (abort_i && (state != IDLE)) state_nx = IDLE;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      k              <= '0;
      total          <= '0;
      err_o          <= 1'b0;
      core_mode_o    <= '0;
      core_adlen_o   <= '0;
      core_datalen_o <= '0;
      core_blk_o     <= '0;
      lo_word        <= '0;
      ct_q           <= '0;
    end else begin
      if (accept) begin
        k              <= '0;
        total          <= req_sum;
        err_o          <= 1'b0;
        core_mode_o    <= cfg_mode_i;
        core_adlen_o   <= cfg_adblk_i;
        core_datalen_o <= {cfg_dblk_i[3:0], 3'b000};
      end else if (((state == LOAD) && (k < ad6)) || (state == WR_HI)) begin
        k <= k_inc;
      end
      if ((state_nx == ERR) && (state != ERR)) err_o <= 1'b1;
      if (state == RD_HI) lo_word <= mem_rdata_i;
      if (state == LOAD) core_blk_o <= {mem_rdata_i, lo_word};
      if ((state == WAIT_CT) && core_ctv_i) ct_q <= core_ct_i;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    case (state)
      RD_LO: mem_addr_o = addr_lo;
      RD_HI: mem_addr_o = addr_hi;
      WR_LO: begin
        mem_addr_o  = addr_lo;
        mem_wdata_o = ct_q[WORD_W-1:0];
        mem_we_o    = 1'b1;
      end
      WR_HI: begin
        mem_addr_o  = addr_hi;
        mem_wdata_o = ct_q[BLK_W-1:WORD_W];
        mem_we_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE) || (state == ERR);
  assign core_start_o = (state == START);

endmodule
`default_nettype wire

// File: tb/tb_ascon_seq.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ascon_seq: randomized jobs against a word-array memory model and expected block/write-back lists.
module tb_ascon_seq;

  localparam int MEM_AW = 5;
  localparam int NW     = 2 ** MEM_AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0, abort = 1'b0;
  logic [1:0]        mode = '0;
  logic [4:0]        adblk = '0, dblk = '0;
  logic              busy, done, err;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata, mem_wdata;
  logic              mem_we;
  logic              core_start;
  logic [1:0]        core_mode;
  logic [4:0]        core_adlen;
  logic [6:0]        core_datalen;
  logic [63:0]       core_blk;
  logic              blk_req = 1'b0;
  logic [63:0]       ct = '0;
  logic              ctv = 1'b0, tv = 1'b0;

  logic [31:0]       mem     [NW];
  logic [31:0]       exp_mem [NW];
  logic              tb_we = 1'b0;
  logic [MEM_AW-1:0] tb_addr = '0;
  logic [31:0]       tb_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ascon_seq #(.MEM_AW(MEM_AW)) dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (rst_n),
    .go_i           (go),
    .abort_i        (abort),
    .cfg_mode_i     (mode),
    .cfg_adblk_i    (adblk),
    .cfg_dblk_i     (dblk),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .mem_addr_o     (mem_addr),
    .mem_rdata_i    (mem_rdata),
    .mem_wdata_o    (mem_wdata),
    .mem_we_o       (mem_we),
    .core_start_o   (core_start),
    .core_mode_o    (core_mode),
    .core_adlen_o   (core_adlen),
    .core_datalen_o (core_datalen),
    .core_blk_o     (core_blk),
    .core_blk_req_i (blk_req),
    .core_ct_i      (ct),
    .core_ctv_i     (ctv),
    .core_tv_i      (tv)
  );

  // Synchronous memory: one-cycle read latency, DUT writes take precedence over bench preload.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr]  <= tb_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < NW; i++) begin
      tb_we      = 1'b1;
      tb_addr    = i[MEM_AW-1:0];
      tb_data    = $urandom;
      exp_mem[i] = tb_data;
      tick();
    end
    tb_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  // Issue go with a legal config; afterwards the DUT sits in START.
  task automatic start_job(input int ad, input int d, input logic [1:0] md);
    mode  = md;
    adblk = ad[4:0];
    dblk  = d[4:0];
    go    = 1'b1;
    tick();
    go = 1'b0;
    check("start_pulse", {62'd0, core_start, busy}, 64'd3);
    check("start_err_clr", 64'(err), 64'd0);
    check("cfg_latch", {50'd0, core_mode, core_adlen, core_datalen},
          {50'd0, md, ad[4:0], 7'(d * 8)});
  endtask

  // Core requests block k; expect {word 2k+1, word 2k} once LOAD has completed.
  task automatic fetch_block(input int k);
    blk_req = 1'b1;
    tick();
    blk_req = 1'b0;
    ctv     = 1'b0;
    check("rd_lo_addr", 64'(mem_addr), 64'(2 * k));
    tick();
    tick();
    tick();
    check("core_blk", core_blk, {exp_mem[2*k+1], exp_mem[2*k]});
  endtask

  task automatic write_back(input int k);
    logic [63:0] c;
    c   = {$urandom, $urandom};
    ct  = c;
    ctv = 1'b1;
    tick();
    ctv = 1'b0;
    ct  = '0;
    check("wr_lo", {mem_we, 26'(mem_addr), mem_wdata}, {1'b1, 26'(2 * k), c[31:0]});
    tick();
    check("wr_hi", {mem_we, 26'(mem_addr), mem_wdata}, {1'b1, 26'(2 * k + 1), c[63:32]});
    tick();
    exp_mem[2*k]   = c[31:0];
    exp_mem[2*k+1] = c[63:32];
  endtask

  task automatic run_job(input int ad, input int d);
    int n;
    n = ad + d;
    preload();
    start_job(ad, d, 2'($urandom));
    tick();
    for (int k = 0; k < n; k++) begin
      // A stray ciphertext strobe while waiting for a request must not cause a write.
      if (k == 0 && ad > 0) begin
        ctv = 1'b1;
        ct  = '1;
      end
      fetch_block(k);
      if (k >= ad) write_back(k);
    end
    check("wait_tag", {62'd0, busy, done}, 64'd2);
    tv = 1'b1;
    tick();
    tv = 1'b0;
    check("done_pulse", {62'd0, done, err}, 64'd2);
    tick();
    check("back_idle", {62'd0, done, busy}, 64'd0);
    check_mem("mem_final");
  endtask

  task automatic bad_cfg(input int ad, input int d);
    mode  = 2'd1;
    adblk = ad[4:0];
    dblk  = d[4:0];
    go    = 1'b1;
    tick();
    go = 1'b0;
    check("err_state", {61'd0, done, err, core_start}, 64'd6);
    tick();
    check("err_after", {61'd0, done, err, busy}, 64'd2);
  endtask

  initial begin
    int ad, d, done_seen, cyc;

    tick();
    tick();
    check("reset_outputs",
          {busy, done, err, mem_we, core_start, core_mode, core_adlen, core_datalen} , '0);
    check("reset_blk", core_blk, 64'd0);
    rst_n = 1'b1;
    tick();

    run_job(1, 2);
    run_job(0, 0);
    run_job(2, 0);
    run_job(0, 3);
    run_job(1, 15);

    for (int it = 0; it < 6; it++) begin
      ad = $urandom_range(0, 16);
      d  = $urandom_range(0, (16 - ad) > 15 ? 15 : (16 - ad));
      run_job(ad, d);
    end

    bad_cfg(10, 7);
    bad_cfg(0, 16);
    run_job(16, 0);

    // go while busy is ignored; abort mid-wait returns to idle without done.
    preload();
    start_job(1, 1, 2'd2);
    tick();
    mode  = 2'd1;
    adblk = 5'd3;
    dblk  = 5'd4;
    go    = 1'b1;
    tick();
    go = 1'b0;
    check("go_busy_cfg", {50'd0, core_start, core_mode, core_adlen, core_datalen},
          {50'd0, 1'b0, 2'd2, 5'd1, 7'd8});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_wait", {62'd0, busy, done}, 64'd0);

    // Abort in WR_LO: only the low word lands in memory.
    preload();
    start_job(0, 2, 2'd3);
    tick();
    fetch_block(0);
    ct  = 64'hA5A5_0F0F_1234_5678;
    ctv = 1'b1;
    tick();
    ctv   = 1'b0;
    abort = 1'b1;
    check("abort_wr_lo", {63'd0, mem_we}, 64'd1);
    tick();
    abort = 1'b0;
    check("abort_idle", {61'd0, busy, done, mem_we}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || mem_we) done_seen++;
      tick();
    end
    check("abort_quiet", 64'(done_seen), 64'd0);
    exp_mem[0] = 32'h1234_5678;
    check_mem("abort_mem");

    // Reset while waiting for ciphertext clears every output.
    preload();
    start_job(0, 1, 2'd1);
    tick();
    fetch_block(0);
    rst_n = 1'b0;
    tick();
    check("rst_mid_outputs",
          {busy, done, err, mem_we, core_start, core_mode, core_adlen, core_datalen, mem_addr, mem_wdata}, '0);
    check("rst_mid_blk", core_blk, 64'd0);
    rst_n = 1'b1;
    tick();

    // Core never requests a block.
    start_job(1, 0, 2'd0);
    tick();
`ifdef ASCON_SEQ_TIMEOUT_EN
    cyc = 0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    check("wdog_done", 64'(done), 64'd1);
    check("wdog_err", 64'(err), 64'd1);
    check("wdog_window", 64'(cyc >= 250 && cyc <= 260), 64'd1);
    tick();
`else
    cyc = 0;
    done_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (done || err || !busy) done_seen++;
      tick();
      cyc++;
    end
    check("no_wdog_wait", {61'd0, busy, done, err}, 64'd4);
    check("no_wdog_quiet", 64'(done_seen), 64'd0);
    fetch_block(0);
    check("no_wdog_resume", {62'd0, busy, done}, 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif
    check("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
